bcd_scan_display: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 57 +++++
 rtl/bcd_to_seg7.sv | 31 +++
 rtl/bcd_scan_display.sv | 104 ++++++++++
 tb/tb_bcd_scan_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// bcd_disp_pkg : shared constants and types for the BCD scanned display
// Rev 1.0
// ============================================================================
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] IDX_S2 = 3'd0;
  localparam logic [2:0] IDX_S1 = 3'd1;
  localparam logic [2:0] IDX_M2 = 3'd2;
  localparam logic [2:0] IDX_M1 = 3'd3;
  localparam logic [2:0] IDX_H2 = 3'd4;
  localparam logic [2:0] IDX_H1 = 3'd5;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
    logic [2:0] s1;
    logic [3:0] s2;
  } time_snap_t;

  // Zero-extended digit shown in a given slot
  function automatic logic [3:0] slot_digit(input time_snap_t t, input logic [2:0] idx);
    logic [3:0] d;
    d = 4'd0;
    case (idx)
      IDX_S2:  d = t.s2;
      IDX_S1:  d = {1'b0, t.s1};
      IDX_M2:  d = t.m2;
      IDX_M1:  d = {1'b0, t.m1};
      IDX_H2:  d = t.h2;
      IDX_H1:  d = {2'b00, t.h1};
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// bcd_to_seg7 : 4-bit BCD to active-low 7-segment decoder, dash for 10..15
// Rev 1.0
// ============================================================================
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// bcd_scan_display : snapshots HH:MM:SS once per frame and multiplexes it onto
//                    one 7-segment bus with active-low anodes and ghost blanking
// Rev 1.0
// ============================================================================
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 1,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            h1,
  input  logic [3:0]            h2,
  input  logic [2:0]            m1,
  input  logic [3:0]            m2,
  input  logic [2:0]            s1,
  input  logic [3:0]            s2,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  time_snap_t            snap_q, snap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  presc_wrap;
  logic                  frame_end;
  logic                  blank_phase;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_n (dec_seg)
  );

  always_comb begin
    presc_wrap   = (presc_q == PRESC_W'(SCAN_DIV - 1));
    frame_end    = presc_wrap && (idx_q == IDX_H1);
    blank_phase  = (presc_q < PRESC_W'(BLANK_CYC));
    cur_digit    = slot_digit(snap_q, idx_q);

    presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_H1) ? IDX_S2 : idx_q + 3'd1;
    end

    // The capture edge is also the edge that starts the next frame at slot 0
    snap_d       = snap_q;
    if (frame_end) begin
      snap_d = '{h1: h1, h2: h2, m1: m1, m2: m2, s1: s1, s2: s2};
    end
    frame_tick_d = frame_end;

    an_d = blank_phase ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << idx_q);

    seg_d = dec_seg;
    if ((BLANK_LEAD != 0) && (idx_q == IDX_H1) && (cur_digit == 4'd0)) begin
      seg_d = SEG_BLANK;
    end

    dp_d = !(!blank_phase && ((idx_q == IDX_M2) || (idx_q == IDX_H2)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= IDX_S2;
      snap_q       <= '0;
      an_q         <= {NUM_DIGITS{1'b1}};
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// tb_bcd_scan_display : directed stimulus with a position-based display model
// Rev 1.0
// ============================================================================
module tb_bcd_scan_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] h1 = '0;
  logic [3:0] h2 = '0;
  logic [2:0] m1 = '0;
  logic [3:0] m2 = '0;
  logic [2:0] s1 = '0;
  logic [3:0] s2 = '0;

  logic [5:0] an, an_nl;
  logic [6:0] seg, seg_nl;
  logic       dp, dp_nl, ft, ft_nl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(1)) dut (
    .clk(clk), .reset(reset), .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .an(an), .seg(seg), .dp(dp), .frame_tick(ft)
  );

  bcd_scan_display #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(0)) dut_nl (
    .clk(clk), .reset(reset), .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .an(an_nl), .seg(seg_nl), .dp(dp_nl), .frame_tick(ft_nl)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: frame position n mod 24 -> slot = pos/4, phase = pos%4 (SCAN_DIV=4)
  int         n = 0;
  int         m_opos = -1;
  int         msnap[6];
  logic [5:0] e_an = '1;
  logic [6:0] e_seg = '1, e_seg_nl = '1;
  logic       e_dp = 1'b1, e_ft = 1'b0;

  always @(posedge clk) begin : model
    int pos, sl, pr;
    if (reset) begin
      n = 0;
      m_opos = -1;
      foreach (msnap[i]) msnap[i] = 0;
      e_an = '1; e_seg = '1; e_seg_nl = '1; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      pos = n % 24;
      sl  = pos / 4;
      pr  = pos % 4;
      e_an     = (pr < 1) ? 6'h3F : ~(6'd1 << sl);
      e_dp     = !(pr >= 1 && (sl == 2 || sl == 4));
      e_seg_nl = seg_of(msnap[sl]);
      e_seg    = (sl == 5 && msnap[5] == 0) ? 7'h7F : e_seg_nl;
      e_ft     = (pos == 23);
      m_opos   = pos;
      if (pos == 23) begin
        msnap[0] = int'(s2); msnap[1] = int'(s1); msnap[2] = int'(m2);
        msnap[3] = int'(m1); msnap[4] = int'(h2); msnap[5] = int'(h1);
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_an", int'(an), 'h3F);
      chk("rst_seg", int'(seg), 'h7F);
      chk("rst_dp", int'(dp), 1);
      chk("rst_ft", int'(ft), 0);
      chk("rst_an_nl", int'(an_nl), 'h3F);
    end else begin
      chk("an", int'(an), int'(e_an));
      chk("dp", int'(dp), int'(e_dp));
      chk("ft", int'(ft), int'(e_ft));
      chk("an_nl", int'(an_nl), int'(e_an));
      chk("dp_nl", int'(dp_nl), int'(e_dp));
      chk("ft_nl", int'(ft_nl), int'(e_ft));
      if (e_an != 6'h3F) begin
        chk("seg", int'(seg), int'(e_seg));
        chk("seg_nl", int'(seg_nl), int'(e_seg_nl));
      end
    end
  end

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_opos != p && k < 200);
    if (m_opos != p) chk("wait_pos_timeout", m_opos, p);
  endtask

  task automatic wait_ft(output int cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ft !== 1'b1 && k < 100);
    if (ft !== 1'b1) chk("wait_ft_timeout", int'(ft), 1);
    cyc = k;
  endtask

  initial begin
    int k;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_an", int'(an), 'h3F);
    chk("async_rst_seg", int'(seg), 'h7F);
    chk("async_rst_dp", int'(dp), 1);
    chk("async_rst_ft", int'(ft), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // First frame after reset: zeros, hours-tens blanked
    wait_pos(0);  chk("lit_pos0_an", int'(an), 'b111111);
    wait_pos(1);  chk("lit_pos1_an", int'(an), 'b111110);
                  chk("lit_pos1_seg", int'(seg), 'b1000000);
    wait_pos(5);  chk("lit_pos5_an", int'(an), 'b111101);
    wait_pos(21); chk("lit_h1_an", int'(an), 'b011111);
                  chk("lit_h1_blank", int'(seg), 'b1111111);
                  chk("lit_h1_noblank", int'(seg_nl), 'b1000000);

    wait_ft(k);
    wait_ft(k);
    chk("ft_period", k, 24);

    // 12:34:56
    h1 = 2'd1; h2 = 4'd2; m1 = 3'd3; m2 = 4'd4; s1 = 3'd5; s2 = 4'd6;
    wait_ft(k);
    wait_pos(1);  chk("lit_s2_6", int'(seg), 'b0000010);
    wait_pos(5);  chk("lit_s1_5", int'(seg), 'b0010010);
    wait_pos(9);  chk("lit_m2_4", int'(seg), 'b0011001);
                  chk("lit_m2_dp", int'(dp), 0);
    wait_pos(17); chk("lit_h2_2", int'(seg), 'b0100100);
                  chk("lit_h2_dp", int'(dp), 0);
    wait_pos(21); chk("lit_h1_1", int'(seg), 'b1111001);

    // Snapshot hold: change mid-frame is invisible until next capture
    wait_pos(1);
    s2 = 4'd7;
    wait_pos(3);  chk("lit_hold_6", int'(seg), 'b0000010);
    wait_ft(k);
    wait_pos(1);  chk("lit_new_7", int'(seg), 'b1111000);

    // Invalid digit and leading-zero blanking
    m2 = 4'hC; h1 = 2'd0;
    wait_ft(k);
    wait_pos(9);  chk("lit_dash", int'(seg), 'b0111111);
    wait_pos(21); chk("lit_lead_blank", int'(seg), 'b1111111);
                  chk("lit_lead_an", int'(an), 'b011111);
                  chk("lit_lead_nl", int'(seg_nl), 'b1000000);

    // Reset mid-frame at slot 3
    wait_pos(13);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_an", int'(an), 'h3F);
    chk("mid_rst_seg", int'(seg), 'h7F);
    chk("mid_rst_dp", int'(dp), 1);
    chk("mid_rst_ft", int'(ft), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("post_rst_an0", int'(an), 'b111111);
      if (k == 2) begin
        chk("post_rst_an1", int'(an), 'b111110);
        chk("post_rst_seg0", int'(seg), 'b1000000);
      end
    end while (ft !== 1'b1 && k < 60);
    chk("post_rst_ft_delay", k, 24);

    repeat (30) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
